// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the four-port memory arbiter: state encoding,
// wait-counter width and the round-robin helpers.
package mem_port_arbiter_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // Returns the first requester with req set, searching from ptr upward (mod 4).
  // If no bit is set, ptr is returned; callers only use the result when req != 0.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] cand;
    logic       found;
    idx   = ptr;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // Converts a requester index into its one-hot grant vector.
  function automatic logic [3:0] to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// Plain N-bit 4:1 multiplexer used to route the granted requester's address.
module Mux4to1Nbit #(
  parameter int N = 64
) (
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic [N-1:0] d2,
  input  logic [N-1:0] d3,
  input  logic [1:0]   S,
  output logic [N-1:0] y
);

  // Select one of the four inputs by S.
  always_comb begin
    y = d0;
    case (S)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter granting one of four requesters access to a shared
// resource. A grant issues a one-cycle start pulse, then waits for done or
// aborts after TIMEOUT wait cycles.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int N       = 64,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [3:0]   req,
  input  logic [N-1:0] addr0,
  input  logic [N-1:0] addr1,
  input  logic [N-1:0] addr2,
  input  logic [N-1:0] addr3,
  input  logic         done,
  output logic [3:0]   gnt,
  output logic [1:0]   sel,
  output logic [N-1:0] addr_out,
  output logic         start,
  output logic         busy,
  output logic         timeout_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  arb_state_t       state, state_next;
  logic [1:0]       ptr, ptr_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       gnt_next;
  logic [1:0]       sel_next;
  logic             start_next;
  logic             timeout_err_next;
  logic [1:0]       idle_winner;
  logic [1:0]       release_ptr;
  logic [1:0]       release_winner;

  assign cnt_inc        = wait_cnt + 8'd1;
  assign release_ptr    = sel + 2'd1;
  assign idle_winner    = rr_pick(req, ptr);
  assign release_winner = rr_pick(req, release_ptr);
  assign busy           = (state == ISSUE) || (state == WAIT);

  // State and registered outputs; reset forces everything idle immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      wait_cnt    <= '0;
      gnt         <= 4'b0000;
      sel         <= 2'd0;
      start       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      wait_cnt    <= wait_cnt_next;
      gnt         <= gnt_next;
      sel         <= sel_next;
      start       <= start_next;
      timeout_err <= timeout_err_next;
    end
  end

  // Next-state logic: arbitrate in IDLE, issue for one cycle, then wait for
  // done (re-arbitrating from sel+1 without an idle bubble) or time out.
  always_comb begin
    state_next       = state;
    ptr_next         = ptr;
    wait_cnt_next    = wait_cnt;
    gnt_next         = gnt;
    sel_next         = sel;
    start_next       = 1'b0;
    timeout_err_next = 1'b0;
    case (state)
      IDLE: begin
        gnt_next = 4'b0000;
        if (|req) begin
          state_next = ISSUE;
          gnt_next   = to_onehot(idle_winner);
          sel_next   = idle_winner;
          start_next = 1'b1;
        end
      end
      ISSUE: begin
        state_next    = WAIT;
        wait_cnt_next = '0;
      end
      WAIT: begin
        if (done) begin
          ptr_next = release_ptr;
          if (|req) begin
            state_next = ISSUE;
            gnt_next   = to_onehot(release_winner);
            sel_next   = release_winner;
            start_next = 1'b1;
          end else begin
            state_next = IDLE;
            gnt_next   = 4'b0000;
          end
        end else if (cnt_inc == TIMEOUT_CNT) begin
          timeout_err_next = 1'b1;
          ptr_next         = release_ptr;
          state_next       = IDLE;
          gnt_next         = 4'b0000;
        end else begin
          wait_cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 4'b0000;
      end
    endcase
  end

  Mux4to1Nbit #(.N(N)) u_addr_mux (
    .d0 (addr0),
    .d1 (addr1),
    .d2 (addr2),
    .d3 (addr3),
    .S  (sel),
    .y  (addr_out)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int N = 64;

  logic         clk;
  logic         reset_n;
  logic [3:0]   req;
  logic [N-1:0] addr0, addr1, addr2, addr3;
  logic         done;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic [N-1:0] addr_out;
  logic         start;
  logic         busy;
  logic         timeout_err;

  int checks_total;
  int checks_passed;

  mem_port_arbiter #(.N(N), .TIMEOUT(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .addr0       (addr0),
    .addr1       (addr1),
    .addr2       (addr2),
    .addr3       (addr3),
    .done        (done),
    .gnt         (gnt),
    .sel         (sel),
    .addr_out    (addr_out),
    .start       (start),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [N-1:0] actual, input logic [N-1:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req_v, input logic done_v);
    req  = req_v;
    done = done_v;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] order [5];

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    addr0 = 64'h0000_0000_0000_A000;
    addr1 = 64'h0000_0000_0000_A111;
    addr2 = 64'h0000_0000_0000_A222;
    addr3 = 64'h0000_0000_0000_A333;
    reset_n = 1'b0;
    applyStimulus(4'b0000, 1'b0);
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;

    // Reset state
    #2;
    checkOutput("rst_gnt", N'(gnt), N'(4'b0000));
    checkOutput("rst_sel", N'(sel), N'(2'd0));
    checkOutput("rst_start", N'(start), N'(1'b0));
    checkOutput("rst_busy", N'(busy), N'(1'b0));
    checkOutput("rst_terr", N'(timeout_err), N'(1'b0));
    checkOutput("rst_addr", addr_out, addr0);
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("idle_gnt", N'(gnt), N'(4'b0000));

    // Single request to port 2
    applyStimulus(4'b0100, 1'b0);
    tick();
    checkOutput("single_gnt", N'(gnt), N'(4'b0100));
    checkOutput("single_sel", N'(sel), N'(2'd2));
    checkOutput("single_start", N'(start), N'(1'b1));
    checkOutput("single_busy", N'(busy), N'(1'b1));
    checkOutput("single_addr", addr_out, addr2);
    applyStimulus(4'b0000, 1'b0);
    tick();
    checkOutput("single_start_off", N'(start), N'(1'b0));
    checkOutput("single_wait_gnt", N'(gnt), N'(4'b0100));
    tick();
    applyStimulus(4'b0000, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b0);
    checkOutput("single_rel_gnt", N'(gnt), N'(4'b0000));
    checkOutput("single_rel_busy", N'(busy), N'(1'b0));
    checkOutput("single_rel_sel", N'(sel), N'(2'd2));
    checkOutput("single_rel_addr", addr_out, addr2);

    // ptr should now be 3
    applyStimulus(4'b1111, 1'b0);
    tick();
    checkOutput("ptr3_gnt", N'(gnt), N'(4'b1000));
    checkOutput("ptr3_sel", N'(sel), N'(2'd3));

    // Fairness: all requesting, done on the second WAIT cycle each grant
    for (int g = 0; g < 5; g++) begin
      tick();
      checkOutput("fair_busy_w0", N'(busy), N'(1'b1));
      tick();
      applyStimulus(4'b1111, 1'b1);
      tick();
      applyStimulus(4'b1111, 1'b0);
      checkOutput($sformatf("fair_gnt%0d", g), N'(gnt), N'(4'b0001 << order[g]));
      checkOutput($sformatf("fair_start%0d", g), N'(start), N'(1'b1));
      checkOutput($sformatf("fair_busy%0d", g), N'(busy), N'(1'b1));
    end

    // Timeout: grant 0 active in ISSUE, done never comes
    applyStimulus(4'b0001, 1'b0);
    for (int w = 0; w < 4; w++) begin
      tick();
      checkOutput($sformatf("to_wait%0d_terr", w), N'(timeout_err), N'(1'b0));
      checkOutput($sformatf("to_wait%0d_gnt", w), N'(gnt), N'(4'b0001));
    end
    tick();
    checkOutput("to_pulse", N'(timeout_err), N'(1'b1));
    checkOutput("to_gnt", N'(gnt), N'(4'b0000));
    checkOutput("to_busy", N'(busy), N'(1'b0));
    applyStimulus(4'b0011, 1'b0);
    tick();
    checkOutput("to_pulse_off", N'(timeout_err), N'(1'b0));
    checkOutput("to_next_gnt", N'(gnt), N'(4'b0010));

    // Done on the same edge the counter reaches TIMEOUT
    applyStimulus(4'b0000, 1'b0);
    for (int w = 0; w < 4; w++) tick();
    applyStimulus(4'b1111, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b0);
    checkOutput("sim_terr", N'(timeout_err), N'(1'b0));
    checkOutput("sim_gnt", N'(gnt), N'(4'b0100));
    checkOutput("sim_start", N'(start), N'(1'b1));

    // Get grant 1 into WAIT, then reset asynchronously
    tick();
    applyStimulus(4'b0000, 1'b1);
    tick();
    applyStimulus(4'b0010, 1'b0);
    tick();
    checkOutput("pre_rst_gnt", N'(gnt), N'(4'b0010));
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_gnt", N'(gnt), N'(4'b0000));
    checkOutput("arst_sel", N'(sel), N'(2'd0));
    checkOutput("arst_busy", N'(busy), N'(1'b0));
    checkOutput("arst_start", N'(start), N'(1'b0));
    #1;
    reset_n = 1'b1;
    applyStimulus(4'b1010, 1'b0);
    tick();
    checkOutput("post_rst_gnt", N'(gnt), N'(4'b0010));
    checkOutput("post_rst_sel", N'(sel), N'(2'd1));

    // Request dropped while granted
    tick();
    applyStimulus(4'b1000, 1'b0);
    tick();
    checkOutput("drop_gnt_w1", N'(gnt), N'(4'b0010));
    applyStimulus(4'b0000, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b0);
    checkOutput("drop_rel_gnt", N'(gnt), N'(4'b0000));

    // Spurious done in IDLE
    applyStimulus(4'b0000, 1'b1);
    tick();
    tick();
    checkOutput("spur_gnt", N'(gnt), N'(4'b0000));
    checkOutput("spur_busy", N'(busy), N'(1'b0));
    checkOutput("spur_start", N'(start), N'(1'b0));
    checkOutput("spur_sel", N'(sel), N'(2'd1));
    applyStimulus(4'b0101, 1'b0);
    tick();
    checkOutput("spur_next_gnt", N'(gnt), N'(4'b0100));
    checkOutput("spur_next_addr", addr_out, addr2);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
